// File: rtl/map_scan.sv
// Scans an 8x8 grid cell by cell against a latched circle and streams one
// inclusion result per cell over a valid/ready port, building a 64-bit map.
module map_scan #(
  parameter int CNT_W = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_center_x,
  input  logic [3:0]       i_center_y,
  input  logic [3:0]       i_center_r,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_cell_valid,
  input  logic             i_cell_ready,
  output logic [5:0]       o_cell_idx,
  output logic             o_cell_hit,
  output logic [63:0]      o_map_bits,
  output logic [CNT_W-1:0] o_hit_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           r_state;
  logic [3:0]       r_cx;
  logic [3:0]       r_cy;
  logic [3:0]       r_r;
  logic [5:0]       r_idx;
  logic [63:0]      r_map;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;

  logic signed [5:0] w_dx;
  logic signed [5:0] w_dy;
  logic [3:0]        w_adx;
  logic [3:0]        w_ady;
  logic [7:0]        w_dx2;
  logic [7:0]        w_dy2;
  logic [8:0]        w_sum;
  logic [7:0]        w_r2;
  logic              w_hit;

  // Offsets span -14..8; squaring the magnitude keeps every product in 8 bits.
  assign w_dx  = $signed({3'b000, r_idx[2:0]}) - $signed({2'b00, r_cx}) + 6'sd1;
  assign w_dy  = $signed({3'b000, r_idx[5:3]}) - $signed({2'b00, r_cy}) + 6'sd1;
  assign w_adx = w_dx[5] ? 4'(-w_dx) : w_dx[3:0];
  assign w_ady = w_dy[5] ? 4'(-w_dy) : w_dy[3:0];
  assign w_dx2 = w_adx * w_adx;
  assign w_dy2 = w_ady * w_ady;
  assign w_sum = {1'b0, w_dx2} + {1'b0, w_dy2};
  assign w_r2  = r_r * r_r;
  assign w_hit = (w_sum <= {1'b0, w_r2});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cx    <= '0;
      r_cy    <= '0;
      r_r     <= '0;
      r_idx   <= '0;
      r_map   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_cx    <= i_center_x;
            r_cy    <= i_center_y;
            r_r     <= i_center_r;
            r_idx   <= '0;
            r_map   <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (i_cell_ready) begin
            r_map[r_idx] <= w_hit;
            if (w_hit) r_count <= r_count + CNT_W'(1);
            // Last cell ends the pass; the index parks at 63 instead of wrapping.
            if (r_idx == 6'd63) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_idx <= r_idx + 6'd1;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_cell_valid = r_busy;
  assign o_cell_idx   = r_idx;
  assign o_cell_hit   = w_hit & r_busy;
  assign o_map_bits   = r_map;
  assign o_hit_count  = r_count;

endmodule

// File: tb/tb_map_scan.sv
// Directed bench for map_scan: a circle-inclusion model checks every presented
// cell, and each scan's latency, transfer count, map and hit count.
module tb_map_scan;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  cx_in;
  logic [3:0]  cy_in;
  logic [3:0]  r_in;
  logic        busy;
  logic        done;
  logic        cell_valid;
  logic        cell_ready;
  logic [5:0]  cell_idx;
  logic        cell_hit;
  logic [63:0] map_bits;
  logic [6:0]  hit_count;

  int errors = 0;
  int checks = 0;
  int m_cx, m_cy, m_r;
  int exp_idx;
  int xfers;

  map_scan #(.CNT_W(7)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_center_x(cx_in), .i_center_y(cy_in), .i_center_r(r_in),
    .o_busy(busy), .o_done(done), .o_cell_valid(cell_valid),
    .i_cell_ready(cell_ready), .o_cell_idx(cell_idx), .o_cell_hit(cell_hit),
    .o_map_bits(map_bits), .o_hit_count(hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_hit(input int cx, input int cy, input int r, input int idx);
    int dx, dy;
    dx = (idx % 8) - cx + 1;
    dy = (idx / 8) - cy + 1;
    return (dx * dx + dy * dy) <= (r * r);
  endfunction

  function automatic logic [63:0] model_map(input int cx, input int cy, input int r);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) m[i] = model_hit(cx, cy, r, i);
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every presented cell must be the next expected index with the model's hit.
  always @(negedge clk) begin
    if (rst_n && cell_valid) begin
      check("cell_idx_seq", 64'(cell_idx), 64'(exp_idx));
      check("cell_hit", 64'(cell_hit), 64'(model_hit(m_cx, m_cy, m_r, int'(cell_idx))));
      if (cell_ready) begin
        xfers++;
        exp_idx++;
      end
    end
  end

  // Starts a scan from IDLE and returns in the DONE cycle (or after a timeout).
  task automatic run_scan(input int cx, input int cy, input int r,
                          input int stall_idx, input int stall_len);
    int cyc;
    int stalls;
    int done_cyc;
    logic [63:0] m;
    cx_in = 4'(cx); cy_in = 4'(cy); r_in = 4'(r);
    start = 1'b1; cell_ready = 1'b1;
    m_cx = cx; m_cy = cy; m_r = r;
    exp_idx = 0; xfers = 0;
    cyc = 0; stalls = stall_len; done_cyc = -1;
    while (cyc < 300 && done_cyc < 0) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      cx_in = 4'($urandom); cy_in = 4'($urandom); r_in = 4'($urandom);
      if (cyc == 1) begin
        check("busy_first_cycle", 64'(busy), 64'd1);
        check("valid_first_cycle", 64'(cell_valid), 64'd1);
      end
      if (cell_valid && int'(cell_idx) == stall_idx && stalls > 0) begin
        cell_ready = 1'b0;
        stalls--;
        start = 1'b1;
        cx_in = 4'd0; cy_in = 4'd0; r_in = 4'd15;
      end else begin
        cell_ready = 1'b1;
      end
      if (done) done_cyc = cyc;
    end
    m = model_map(cx, cy, r);
    check("done_cycle", 64'(done_cyc), 64'(65 + stall_len));
    check("busy_in_done", 64'(busy), 64'd0);
    check("xfer_count", 64'(xfers), 64'd64);
    check("map_bits", map_bits, m);
    check("hit_count", 64'(hit_count), 64'($countones(m)));
    $display("scan cx=%0d cy=%0d r=%0d stall=%0d: done@%0d map=%h count=%0d",
             cx, cy, r, stall_len, done_cyc, map_bits, hit_count);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; start = 1'b0; cell_ready = 1'b0;
    cx_in = '0; cy_in = '0; r_in = '0;
    m_cx = 0; m_cy = 0; m_r = 0; exp_idx = 0; xfers = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(cell_valid), 64'd0);
    check("rst_map", map_bits, 64'd0);
    check("rst_count", 64'(hit_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single hit at the origin cell.
    run_scan(1, 1, 0, -1, 0);
    check("lit_map_r0", map_bits, 64'h1);
    check("lit_count_r0", 64'(hit_count), 64'd1);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    @(posedge clk); #1;
    check("map_hold_idle", map_bits, 64'h1);

    // Plus-shaped hit pattern.
    run_scan(3, 3, 1, -1, 0);
    check("lit_map_plus", map_bits, 64'h0000_0000_040E_0400);
    check("lit_count_plus", 64'(hit_count), 64'd5);
    @(posedge clk); #1;

    // Whole grid covered.
    run_scan(4, 4, 15, -1, 0);
    check("lit_map_all", map_bits, 64'hFFFF_FFFF_FFFF_FFFF);
    check("lit_count_all", 64'(hit_count), 64'd64);
    @(posedge clk); #1;

    // Off-grid centre; a start in the DONE cycle must be ignored.
    run_scan(15, 15, 2, -1, 0);
    check("lit_map_none", map_bits, 64'd0);
    check("lit_count_none", 64'(hit_count), 64'd0);
    start = 1'b1; cx_in = 4'd4; cy_in = 4'd4; r_in = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_in_done_ignored", 64'(busy), 64'd0);
    check("map_after_done_start", map_bits, 64'd0);

    // Backpressure at idx 5 with start pulsed; accepted start right after IDLE entry.
    run_scan(3, 3, 1, 5, 3);
    check("lit_map_stall", map_bits, 64'h0000_0000_040E_0400);
    @(posedge clk); #1;

    // Reset mid-scan at idx 30.
    cx_in = 4'd4; cy_in = 4'd4; r_in = 4'd15; start = 1'b1; cell_ready = 1'b1;
    m_cx = 4; m_cy = 4; m_r = 15; exp_idx = 0; xfers = 0;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (cell_idx != 6'd30 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reach_idx30", 64'(cell_idx), 64'd30);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_valid", 64'(cell_valid), 64'd0);
    check("arst_idx", 64'(cell_idx), 64'd0);
    check("arst_hit", 64'(cell_hit), 64'd0);
    check("arst_map", map_bits, 64'd0);
    check("arst_count", 64'(hit_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_resume_busy", 64'(busy), 64'd0);
    check("no_resume_idx", 64'(cell_idx), 64'd0);
    run_scan(2, 5, 3, -1, 0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
